ext_obi_stream_master: RTL and testbench

EXT_OBI_STREAM_MASTER -- requirements
Module: ext_obi_stream_master

---
 rtl/ext_obi_stream_master.sv | 147 ++++++++++++++
 tb/tb_ext_obi_stream_master.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_obi_stream_master.sv
// OBI master that streams len consecutive 32-bit words from/to base_addr.
// Writes carry seed+k; reads are summed into rd_sum_o. One request outstanding at a time.
module ext_obi_stream_master #(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 write_i,
    input  logic [31:0]          base_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic [31:0]          seed_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [31:0]          rd_sum_o,
    output logic                 obi_req_o,
    output logic                 obi_we_o,
    output logic [3:0]           obi_be_o,
    output logic [31:0]          obi_addr_o,
    output logic [31:0]          obi_wdata_o,
    input  logic                 obi_gnt_i,
    input  logic                 obi_rvalid_i,
    input  logic [31:0]          obi_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] k_q, k_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 write_q, write_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rd_sum_q, rd_sum_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            k_q      <= '0;
            len_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_sum_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            len_q    <= len_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_sum_q <= rd_sum_d;
            err_q    <= err_d;
        end
    end

    // addr_q and wdata_q track base+4k and seed+k directly, so wrap is plain 32-bit overflow.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        len_d    = len_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_sum_d = rd_sum_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    write_d = write_i;
                    addr_d  = base_addr_i;
                    wdata_d = seed_i;
                    len_d   = len_i;
                    k_d     = '0;
                    err_d   = 1'b0;
                    if (!write_i) begin
                        rd_sum_d = '0;
                    end
                    if (base_addr_i[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (len_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (obi_gnt_i) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                if (obi_rvalid_i) begin
                    if (!write_q) begin
                        rd_sum_d = rd_sum_q + obi_rdata_i;
                    end
                    if (k_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + LEN_WIDTH'(1);
                        addr_d  = addr_q + 32'd4;
                        wdata_d = wdata_q + 32'd1;
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields are decoded from state so reset drops them in the same instant.
    always_comb begin
        obi_req_o   = 1'b0;
        obi_we_o    = 1'b0;
        obi_be_o    = 4'h0;
        obi_addr_o  = '0;
        obi_wdata_o = '0;
        if (state_q == REQ) begin
            obi_req_o   = 1'b1;
            obi_we_o    = write_q;
            obi_be_o    = 4'hF;
            obi_addr_o  = addr_q;
            obi_wdata_o = write_q ? wdata_q : 32'd0;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign err_o    = err_q;
    assign rd_sum_o = rd_sum_q;

endmodule

// File: tb/tb_ext_obi_stream_master.sv
// Scoreboard bench for ext_obi_stream_master: directed transfers, granted requests
// are popped from an expected queue by an independent monitor.
module tb_ext_obi_stream_master;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic        write_i;
    logic [31:0] base_addr_i;
    logic [15:0] len_i;
    logic [31:0] seed_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rd_sum_o;
    logic        obi_req_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_addr_o;
    logic [31:0] obi_wdata_o;
    logic        obi_gnt_i;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;

    ext_obi_stream_master #(.LEN_WIDTH(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .write_i      (write_i),
        .base_addr_i  (base_addr_i),
        .len_i        (len_i),
        .seed_i       (seed_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rd_sum_o     (rd_sum_o),
        .obi_req_o    (obi_req_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_addr_o   (obi_addr_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i)
    );

    int          errors = 0;
    int          checks = 0;
    int          txn_cnt = 0;
    int          done_cnt = 0;
    int          gnt_delay = 0;
    logic        rv_hold = 1'b0;
    txn_t        exp_q[$];
    logic [31:0] rdata_q[$];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Memory/interconnect model: gnt after gnt_delay stall cycles, rvalid the cycle after gnt.
    initial begin
        logic pending;
        int   stall;
        pending = 1'b0;
        stall = 0;
        obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            obi_gnt_i = 1'b0;
            obi_rvalid_i = 1'b0;
            obi_rdata_i = '0;
            if (!rst_ni) begin
                pending = 1'b0;
                stall = 0;
            end else if (pending) begin
                if (!rv_hold) begin
                    obi_rvalid_i = 1'b1;
                    obi_rdata_i = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'd0;
                    pending = 1'b0;
                end
            end else if (obi_req_o) begin
                if (stall >= gnt_delay) begin
                    obi_gnt_i = 1'b1;
                    pending = 1'b1;
                    stall = 0;
                end else begin
                    stall++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each granted request, checks stall stability, counts done pulses.
    initial begin
        logic        stalled;
        logic [31:0] p_addr;
        logic [31:0] p_wdata;
        logic        p_we;
        logic [3:0]  p_be;
        txn_t        e;
        stalled = 1'b0;
        p_addr = '0;
        p_wdata = '0;
        p_we = 1'b0;
        p_be = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                stalled = 1'b0;
            end else begin
                if (done_o) done_cnt++;
                if (stalled) begin
                    check("stall_req",   {31'd0, obi_req_o}, 32'd1);
                    check("stall_addr",  obi_addr_o, p_addr);
                    check("stall_wdata", obi_wdata_o, p_wdata);
                    check("stall_we",    {31'd0, obi_we_o}, {31'd0, p_we});
                    check("stall_be",    {28'd0, obi_be_o}, {28'd0, p_be});
                end
                if (obi_req_o && obi_gnt_i) begin
                    txn_cnt++;
                    $display("txn %0d: addr=0x%08h we=%0b be=0x%h wdata=0x%08h",
                             txn_cnt, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got request addr=0x%08h required no request", obi_addr_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn_addr",  obi_addr_o, e.addr);
                        check("txn_we",    {31'd0, obi_we_o}, {31'd0, e.we});
                        check("txn_wdata", obi_wdata_o, e.wdata);
                        check("txn_be",    {28'd0, obi_be_o}, 32'hF);
                    end
                end
                stalled = obi_req_o && !obi_gnt_i;
                p_addr = obi_addr_o;
                p_wdata = obi_wdata_o;
                p_we = obi_we_o;
                p_be = obi_be_o;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the start-sampling edge.
    task automatic start_xfer(input logic wr, input logic [31:0] base, input logic [15:0] len,
                              input logic [31:0] seed);
        txn_t t;
        if (base[1:0] == 2'b00) begin
            for (int k = 0; k < int'(len); k++) begin
                t.addr = base + 32'(4 * k);
                t.we = wr;
                t.wdata = wr ? seed + 32'(k) : 32'd0;
                exp_q.push_back(t);
            end
        end
        write_i = wr;
        base_addr_i = base;
        len_i = len;
        seed_i = seed;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Latency counts edges from the start-sampling edge (that edge itself is 1).
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done_o && lat < 300) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        if (!done_o) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_o within %0d cycles required done_o", lat);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},    {31'd0, obi_req_o}, 32'd0);
        check({tag, "_we"},     {31'd0, obi_we_o}, 32'd0);
        check({tag, "_be"},     {28'd0, obi_be_o}, 32'd0);
        check({tag, "_addr"},   obi_addr_o, 32'd0);
        check({tag, "_wdata"},  obi_wdata_o, 32'd0);
        check({tag, "_busy"},   {31'd0, busy_o}, 32'd0);
        check({tag, "_done"},   {31'd0, done_o}, 32'd0);
        check({tag, "_err"},    {31'd0, err_o}, 32'd0);
        check({tag, "_rd_sum"}, rd_sum_o, 32'd0);
    endtask

    initial begin
        int lat;
        int n0;
        int d0;
        bit found;
        start_i = 1'b0;
        write_i = 1'b0;
        base_addr_i = '0;
        len_i = '0;
        seed_i = '0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Zero-wait write burst
        start_xfer(1'b1, 32'h2000_0000, 16'd3, 32'h10);
        wait_done(1, lat);
        check("wr3_latency", 32'(lat), 32'd7);
        @(posedge clk_i);
        #1;
        check("wr3_busy_after", {31'd0, busy_o}, 32'd0);
        check("wr3_done_after", {31'd0, done_o}, 32'd0);

        // Read burst with 3 stall cycles before each gnt; sum wraps to 5
        gnt_delay = 3;
        rdata_q = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF};
        start_xfer(1'b0, 32'h1000_0000, 16'd4, 32'h55);
        wait_done(1, lat);
        check("rd4_latency", 32'(lat), 32'd21);
        check("rd4_sum", rd_sum_o, 32'h0000_0005);
        gnt_delay = 0;
        @(posedge clk_i);
        #1;

        // Misaligned base: no requests, sticky err, single done
        n0 = txn_cnt;
        d0 = done_cnt;
        start_xfer(1'b1, 32'h2000_0002, 16'd2, 32'h0);
        check("mis_err_set", {31'd0, err_o}, 32'd1);
        wait_done(1, lat);
        check("mis_latency", 32'(lat), 32'd1);
        @(posedge clk_i);
        #1;
        check("mis_err_sticky", {31'd0, err_o}, 32'd1);
        check("mis_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("mis_no_req", 32'(txn_cnt - n0), 32'd0);
        start_xfer(1'b1, 32'h3000_0000, 16'd1, 32'h0000_ABCD);
        check("err_cleared", {31'd0, err_o}, 32'd0);
        wait_done(1, lat);
        check("wr1_latency", 32'(lat), 32'd3);
        check("rd_sum_kept", rd_sum_o, 32'h0000_0005);
        @(posedge clk_i);
        #1;

        // len 0 read: immediate done, no request, sum cleared by the read start
        n0 = txn_cnt;
        start_xfer(1'b0, 32'h5000_0000, 16'd0, 32'h0);
        wait_done(1, lat);
        check("len0_latency", 32'(lat), 32'd1);
        check("len0_rd_sum", rd_sum_o, 32'd0);
        @(posedge clk_i);
        #1;
        check("len0_done_low", {31'd0, done_o}, 32'd0);
        check("len0_no_req", 32'(txn_cnt - n0), 32'd0);

        // start pulsed while busy must be ignored
        n0 = txn_cnt;
        d0 = done_cnt;
        start_xfer(1'b1, 32'h6000_0000, 16'd2, 32'h100);
        write_i = 1'b0;
        base_addr_i = 32'h7000_0000;
        len_i = 16'd5;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done(2, lat);
        check("busy_latency", 32'(lat), 32'd5);
        repeat (4) @(posedge clk_i);
        #1;
        check("busy_txn_cnt", 32'(txn_cnt - n0), 32'd2);
        check("busy_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("busy_idle", {31'd0, busy_o}, 32'd0);

        // Address wrap past 0xFFFFFFFC, wdata wraps too
        start_xfer(1'b1, 32'hFFFF_FFF8, 16'd3, 32'hFFFF_FFFF);
        wait_done(1, lat);
        check("wrap_latency", 32'(lat), 32'd7);
        @(posedge clk_i);
        #1;

        // Reset during WAIT_R of word 1 of 4
        n0 = txn_cnt;
        rdata_q = '{32'd10, 32'd20, 32'd30, 32'd40};
        start_xfer(1'b0, 32'h4000_0000, 16'd4, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk_i);
            #1;
            if (txn_cnt == n0 + 2) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL rst_wait: got %0d requests required %0d", txn_cnt - n0, 2);
        end
        rv_hold = 1'b1;
        @(posedge clk_i);
        #2;
        check("rst_pre_wait_busy", {31'd0, busy_o}, 32'd1);
        d0 = done_cnt;
        rst_ni = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_q.delete();
        rdata_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        rv_hold = 1'b0;
        rst_ni = 1'b1;
        rdata_q = '{32'd7, 32'd8};
        start_xfer(1'b0, 32'h4000_0100, 16'd2, 32'h0);
        wait_done(1, lat);
        check("post_rst_latency", 32'(lat), 32'd5);
        check("post_rst_sum", rd_sum_o, 32'h0000_000F);
        repeat (2) @(posedge clk_i);
        #1;
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
